// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared constants for the SPI transaction controller: FSM state
//            encoding, default chip-select timing, FIFO sizing helpers.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Controller FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_RECOVER = 3'd5;

  // Default sizing and chip-select timing (in clk cycles)
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int LEN_W_DEF      = 8;
  localparam int CS_SETUP_DEF   = 2;
  localparam int CS_HOLD_DEF    = 2;
  localparam int CS_IDLE_DEF    = 2;

  // Pointer width for a power-of-two FIFO, never narrower than one bit
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Largest of three timing constants, used to size the shared down-counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO with full/empty flags.
//            Push and pop may coincide at any occupancy; a push while full
//            is only accepted when a pop frees the slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int          PW      = ptr_w(DEPTH);
  localparam logic [PW:0] c_DEPTH = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == c_DEPTH);
  assign o_empty   = (r_count == '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_pop     = i_rd_en && !o_empty;
  assign w_push    = i_wr_en && (!o_full || w_pop);

  // Storage array; contents need no reset since empty masks stale data
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_ctrl
// Brief    : Multi-byte SPI transaction controller. Buffers host TX bytes,
//            sequences chip select and hands one byte at a time to the byte
//            master, optionally capturing received bytes into an RX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int CS_SETUP   = CS_SETUP_DEF,
  parameter int CS_HOLD    = CS_HOLD_DEF,
  parameter int CS_IDLE    = CS_IDLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_rx_en,
  input  logic             tx_wr_en,
  input  logic [7:0]       tx_wr_data,
  output logic             tx_full,
  output logic             tx_ovf,
  input  logic             rx_rd_en,
  output logic [7:0]       rx_rd_data,
  output logic             rx_empty,
  output logic             busy,
  output logic             xfer_done,
  output logic             cs_n,
  output logic             m_start,
  output logic [7:0]       m_tx_data,
  input  logic [7:0]       m_rx_data,
  input  logic             m_done
);

  localparam int               CNT_MAX  = max3(CS_SETUP, CS_HOLD, CS_IDLE);
  localparam int               CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] c_SETUP  = CNT_W'(CS_SETUP);
  // The m_done cycle itself counts as the first hold cycle
  localparam logic [CNT_W-1:0] c_HOLD_R = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] c_IDLE   = CNT_W'(CS_IDLE);
  localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_rem;
  logic             r_rx_en;
  logic             r_cs_n;
  logic             r_xfer_done;
  logic             r_tx_ovf;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [LEN_W-1:0] w_rem_nxt;
  logic             w_rx_en_nxt;
  logic             w_xfer_done_nxt;

  logic [7:0]       w_tx_head;
  logic             w_tx_empty;
  logic             w_tx_full;
  logic             w_rx_full;
  logic             w_can_issue;
  logic             w_rx_push;

  spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (tx_wr_en),
    .i_wr_data (tx_wr_data),
    .i_rd_en   (m_start),
    .o_rd_data (w_tx_head),
    .o_full    (w_tx_full),
    .o_empty   (w_tx_empty)
  );

  spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_rx_push),
    .i_wr_data (m_rx_data),
    .i_rd_en   (rx_rd_en),
    .o_rd_data (rx_rd_data),
    .o_full    (w_rx_full),
    .o_empty   (rx_empty)
  );

  // Only one byte is ever in flight, so RX space checked at issue holds at m_done
  assign w_can_issue = !w_tx_empty && !(r_rx_en && w_rx_full);
  assign w_rx_push   = (r_state == ST_WAIT) && m_done && r_rx_en;

  assign m_start   = (r_state == ST_ISSUE) && w_can_issue;
  assign m_tx_data = m_start ? w_tx_head : 8'h00;
  assign cmd_ready = (r_state == ST_IDLE) && !rst;
  assign busy      = (r_state != ST_IDLE);
  assign cs_n      = r_cs_n;
  assign xfer_done = r_xfer_done;
  assign tx_full   = w_tx_full;
  assign tx_ovf    = r_tx_ovf;

  // Next-state and datapath decode for the transaction sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rem_nxt       = r_rem;
    w_rx_en_nxt     = r_rx_en;
    w_xfer_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_rem_nxt   = cmd_len;
          w_rx_en_nxt = cmd_rx_en;
          w_cnt_nxt   = c_SETUP;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt <= c_ONE) w_state_nxt = ST_ISSUE;
        else                w_cnt_nxt   = r_cnt - c_ONE;
      end
      ST_ISSUE: begin
        if (w_can_issue) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_done) begin
          if (r_rem == '0) begin
            if (CS_HOLD <= 1) begin
              w_state_nxt     = ST_RECOVER;
              w_cnt_nxt       = c_IDLE;
              w_xfer_done_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_HOLD;
              w_cnt_nxt   = c_HOLD_R;
            end
          end else begin
            w_rem_nxt   = r_rem - LEN_W'(1);
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_HOLD: begin
        if (r_cnt <= c_ONE) begin
          w_state_nxt     = ST_RECOVER;
          w_cnt_nxt       = c_IDLE;
          w_xfer_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - c_ONE;
        end
      end
      ST_RECOVER: begin
        if (r_cnt <= c_ONE) w_state_nxt = ST_IDLE;
        else                w_cnt_nxt   = r_cnt - c_ONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer registers; cs_n is registered from the next state to stay glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_rx_en     <= 1'b0;
      r_cs_n      <= 1'b1;
      r_xfer_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rem       <= w_rem_nxt;
      r_rx_en     <= w_rx_en_nxt;
      r_cs_n      <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RECOVER);
      r_xfer_done <= w_xfer_done_nxt;
    end
  end

  // Sticky overflow flag: a TX write dropped because no slot was free
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ovf <= 1'b0;
    end else if (tx_wr_en && w_tx_full && !m_start) begin
      r_tx_ovf <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer_ctrl
// Brief    : Scoreboard bench for spi_xfer_ctrl with an echoing byte master.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_xfer_ctrl;

  localparam int DEPTH = 8;
  localparam int LW    = 8;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int IDLE  = 2;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_rx_en = 1'b0;
  logic          tx_wr_en = 1'b0;
  logic [7:0]    tx_wr_data = 8'h00;
  logic          tx_full;
  logic          tx_ovf;
  logic          rx_rd_en = 1'b0;
  logic [7:0]    rx_rd_data;
  logic          rx_empty;
  logic          busy;
  logic          xfer_done;
  logic          cs_n;
  logic          m_start;
  logic [7:0]    m_tx_data;
  logic [7:0]    m_rx_data = 8'h00;
  logic          m_done = 1'b0;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(
    .FIFO_DEPTH(DEPTH), .LEN_W(LW), .CS_SETUP(SETUP), .CS_HOLD(HOLD), .CS_IDLE(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_rx_en(cmd_rx_en), .tx_wr_en(tx_wr_en),
    .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_ovf(tx_ovf),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty),
    .busy(busy), .xfer_done(xfer_done), .cs_n(cs_n), .m_start(m_start),
    .m_tx_data(m_tx_data), .m_rx_data(m_rx_data), .m_done(m_done)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  int n_start = 0, n_xdone = 0;
  int t_csfall = 0, t_csrise = 0, t_done = 0, t_xdone = 0, t_ready = 0, t_start0 = 0;
  bit first_pending = 1'b0;
  logic p_cs_n = 1'b1, p_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Byte master model: echoes each started byte back after LAT cycles
  initial begin
    forever begin
      @(negedge clk);
      if (m_start) begin
        logic [7:0] d;
        d = m_tx_data;
        repeat (LAT) @(posedge clk);
        #1 m_done = 1'b1; m_rx_data = d;
        @(posedge clk);
        #1 m_done = 1'b0;
      end
    end
  end

  // Monitor: timestamps events and pops the scoreboards when the DUT presents data
  always @(negedge clk) begin
    if (!cs_n && p_cs_n) begin t_csfall = cyc; first_pending = 1'b1; end
    if (cs_n && !p_cs_n) t_csrise = cyc;
    if (cmd_ready && !p_ready) t_ready = cyc;
    if (m_done) t_done = cyc;
    if (xfer_done) begin t_xdone = cyc; n_xdone++; end
    if (m_start) begin
      if (first_pending) begin t_start0 = cyc; first_pending = 1'b0; end
      n_start++;
      if (exp_tx.size() == 0) chk("tx_sb_underflow", exp_tx.size(), 1);
      else                    chk("m_tx_data", int'(m_tx_data), int'(exp_tx.pop_front()));
    end
    if (rx_rd_en && !rx_empty) begin
      if (exp_rx.size() == 0) chk("rx_sb_underflow", exp_rx.size(), 1);
      else                    chk("rx_rd_data", int'(rx_rd_data), int'(exp_rx.pop_front()));
    end
    p_cs_n  = cs_n;
    p_ready = cmd_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [7:0] b, input bit sb_tx, input bit sb_rx);
    tx_wr_en = 1'b1; tx_wr_data = b;
    if (sb_tx) exp_tx.push_back(b);
    if (sb_rx) exp_rx.push_back(b);
    tick();
    tx_wr_en = 1'b0;
  endtask

  task automatic send_cmd(input logic [LW-1:0] len, input logic rxe);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    chk("cmd_ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_len = len; cmd_rx_en = rxe;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    chk("idle_wait", int'(busy), 0);
    tick();
  endtask

  task automatic rx_pop();
    rx_rd_en = 1'b1;
    tick();
    rx_rd_en = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, nvec=%0d nerr=%0d", nvec, nerr);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;

    // Reset state
    repeat (3) tick();
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    rst = 1'b0;
    tick();
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_cmd_ready_after", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_xfer_done", int'(xfer_done), 0);
    chk("rst_m_start", int'(m_start), 0);
    chk("rst_m_tx_data", int'(m_tx_data), 0);
    chk("rst_tx_ovf", int'(tx_ovf), 0);
    chk("rst_tx_full", int'(tx_full), 0);
    chk("rst_rx_empty", int'(rx_empty), 1);

    // Two-byte echo transfer with RX capture
    base = n_start;
    tx_write(8'hA5, 1'b1, 1'b1);
    tx_write(8'h3C, 1'b1, 1'b1);
    send_cmd(8'd1, 1'b1);
    wait_idle();
    chk("t1_starts", n_start - base, 2);
    chk("t1_setup_lat", t_start0 - t_csfall, SETUP);
    chk("t1_hold_lat", t_csrise - t_done, HOLD);
    chk("t1_xdone_with_cs", t_xdone, t_csrise);
    rx_pop();
    rx_pop();
    chk("t1_rx_empty", int'(rx_empty), 1);

    // TX underrun: stall in ISSUE with chip select held
    base = n_start;
    tx_write(8'h11, 1'b1, 1'b1);
    send_cmd(8'd2, 1'b1);
    repeat (20) tick();
    chk("t2_stall_starts", n_start - base, 1);
    chk("t2_stall_cs_n", int'(cs_n), 0);
    chk("t2_stall_busy", int'(busy), 1);
    tx_write(8'h22, 1'b1, 1'b1);
    tx_write(8'h33, 1'b1, 1'b1);
    wait_idle();
    chk("t2_starts", n_start - base, 3);
    for (int i = 0; i < 3; i++) rx_pop();
    chk("t2_rx_empty", int'(rx_empty), 1);

    // RX back-pressure: ten bytes through an eight-deep RX FIFO
    base = n_start;
    for (int i = 0; i < 8; i++) tx_write(8'h80 + 8'(i), 1'b1, 1'b1);
    send_cmd(8'd9, 1'b1);
    repeat (20) tick();
    tx_write(8'h88, 1'b1, 1'b1);
    tx_write(8'h89, 1'b1, 1'b1);
    repeat (60) tick();
    chk("t3_bp_starts8", n_start - base, 8);
    chk("t3_bp_cs_n", int'(cs_n), 0);
    rx_pop();
    repeat (20) tick();
    chk("t3_bp_starts9", n_start - base, 9);
    rx_pop();
    repeat (20) tick();
    chk("t3_bp_starts10", n_start - base, 10);
    wait_idle();
    n = 0;
    while (!rx_empty && n < 16) begin rx_pop(); n++; end
    chk("t3_rx_count", n, 8);
    chk("t3_rx_sb_drained", exp_rx.size(), 0);

    // Single byte, RX capture disabled
    base = n_start;
    tx_write(8'h7E, 1'b1, 1'b0);
    send_cmd(8'd0, 1'b0);
    wait_idle();
    chk("t4_starts", n_start - base, 1);
    chk("t4_rx_empty", int'(rx_empty), 1);
    chk("t4_idle_gap", t_ready - t_xdone, IDLE);

    // TX overflow: ninth write into a full FIFO is dropped
    base = n_start;
    for (int i = 0; i < 8; i++) tx_write(8'hD0 + 8'(i), 1'b1, 1'b0);
    tx_write(8'hEE, 1'b0, 1'b0);
    chk("t5_tx_full", int'(tx_full), 1);
    chk("t5_tx_ovf", int'(tx_ovf), 1);
    send_cmd(8'd7, 1'b0);
    wait_idle();
    chk("t5_starts", n_start - base, 8);
    chk("t5_tx_sb_drained", exp_tx.size(), 0);
    chk("t5_tx_full_after", int'(tx_full), 0);

    // Abort: reset while waiting on the master
    base = n_xdone;
    tx_write(8'h55, 1'b1, 1'b0);
    tx_write(8'h66, 1'b0, 1'b0);
    send_cmd(8'd1, 1'b1);
    n = 0;
    while (!m_start && n < 50) begin tick(); n++; end
    chk("t6_start_seen", int'(m_start), 1);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_abort_cs_n", int'(cs_n), 1);
    chk("t6_abort_busy", int'(busy), 0);
    chk("t6_abort_rx_empty", int'(rx_empty), 1);
    rst = 1'b0;
    repeat (10) tick();
    chk("t6_no_xfer_done", n_xdone - base, 0);
    chk("t6_late_rx_empty", int'(rx_empty), 1);
    chk("t6_late_busy", int'(busy), 0);
    chk("t6_tx_ovf_cleared", int'(tx_ovf), 0);
    chk("t6_tx_sb_drained", exp_tx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
